pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Generates operand forwarding selects, load-use stalls and branch flushes.
- Runs a memory-wait FSM that freezes F..M while the data memory is not ready, and forces a bubble into the M→W register.
- Halts the core on a data-memory timeout and keeps a stall-cycle performance counter.

---
 rtl/pipeline_pkg.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/hazard_fwd_unit.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
//   ctrl_state_t : memory-wait FSM states (RUN / WAIT / HALT)
//   fwd_sel_t    : E-stage operand forwarding select encoding
//   fwd_select() : forwarding priority rule (M over W, x0 never forwarded)
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0033;

  // The M stage holds the younger result, so it wins over W.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and the controller.
//   master : pipeline side, drives register indices / stage status and
//            receives forwarding, stall, flush and memory controls
//   slave  : controller side (pipeline_hazard_ctrl)
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic             MemReqM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             dmem_ready;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             dmem_req;
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, RdW, RegWriteW, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, dmem_req, mem_err, state_o, stall_cycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, RdW, RegWriteW, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, dmem_req, mem_err, state_o, stall_cycles
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Purely combinational forwarding and load-use detection.
//   Rs1D/Rs2D        : sources of the instruction in D
//   Rs1E/Rs2E/RdE    : sources and destination of the instruction in E
//   ResultSrcE       : E result select (load when RESULT_SRC_LOAD)
//   RdM/RegWriteM    : M destination / write enable
//   RdW/RegWriteW    : W destination / write enable
//   ForwardAE/BE     : operand A/B select for E
//   lw_hazard        : raw load-use hazard, not yet qualified by freeze
module hazard_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  output fwd_sel_t   ForwardAE,
  output fwd_sel_t   ForwardBE,
  output logic       lw_hazard
);

  always_comb begin
    ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  always_comb begin
    lw_hazard = 1'b0;
    if ((ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
        ((RdE == Rs1D) || (RdE == Rs2D))) begin
      lw_hazard = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard / sequencing controller for the 5-stage RV32 pipeline.
//   clk, rst : core clock, asynchronous active-high reset
//   hz       : slave side of pipeline_hazard_ctrl_if (forwarding selects,
//              stalls, flushes, data-memory request, FSM state, error flag
//              and saturating stall-cycle counter)
// A data-memory wait freezes F..M and bubbles M->W; MEM_TIMEOUT consecutive
// wait cycles halt the core until reset.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int                WCNT_W       = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_cycles_q;

  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic              lw_hazard;

  logic              halt;
  logic              mem_stall;
  logic              freeze;
  logic              lw_stall;
  logic              stall_f;

  hazard_fwd_unit u_fwd (
    .Rs1D       (hz.Rs1D),
    .Rs2D       (hz.Rs2D),
    .Rs1E       (hz.Rs1E),
    .Rs2E       (hz.Rs2E),
    .RdE        (hz.RdE),
    .ResultSrcE (hz.ResultSrcE),
    .RdM        (hz.RdM),
    .RegWriteM  (hz.RegWriteM),
    .RdW        (hz.RdW),
    .RegWriteW  (hz.RegWriteW),
    .ForwardAE  (fwd_a),
    .ForwardBE  (fwd_b),
    .lw_hazard  (lw_hazard)
  );

  // A freeze holds E, so a taken branch there stays visible and its flush
  // simply fires on the first unfrozen cycle instead of being lost.
  always_comb begin
    halt      = (state_q == HALT);
    mem_stall = !halt && hz.MemReqM && !hz.dmem_ready;
    freeze    = mem_stall || halt;
    lw_stall  = !freeze && lw_hazard;
    stall_f   = freeze || lw_stall;
  end

  always_comb begin
    hz.ForwardAE    = fwd_a;
    hz.ForwardBE    = fwd_b;
    hz.StallF       = stall_f;
    hz.StallD       = stall_f;
    hz.StallE       = freeze;
    hz.StallM       = freeze;
    hz.FlushD       = !freeze && hz.PCSrcE;
    hz.FlushE       = !freeze && (hz.PCSrcE || lw_stall);
    hz.FlushW       = freeze;
    hz.dmem_req     = hz.MemReqM && !halt;
    hz.mem_err      = mem_err_q;
    hz.state_o      = state_q;
    hz.stall_cycles = stall_cycles_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) state_d = WAIT;
      end
      WAIT: begin
        if (mem_stall && (wait_cnt_q == TIMEOUT_LAST)) begin
          state_d = HALT;
        end else if (hz.dmem_ready) begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= mem_stall ? (wait_cnt_q + WCNT_W'(1)) : '0;
      if (state_d == HALT) begin
        mem_err_q <= 1'b1;
      end
      if (stall_f && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          sf, sd, se, sm;
    logic          fd, fe, fw;
    logic          dreq;
    logic          err;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  logic [1:0]    m_state;
  int            m_wcnt;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
    hz.ResultSrcE = '0; hz.PCSrcE = 1'b0; hz.RdM = '0; hz.RegWriteM = 1'b0;
    hz.MemReqM = 1'b0; hz.RdW = '0; hz.RegWriteW = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 2'b00; m_wcnt = 0; m_err = 1'b0; m_cnt = '0;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    exp_t          e;
    logic          halt, mst, frz, lw;
    logic [1:0]    n_state;
    #1;
    halt = (m_state == 2'b10);
    mst  = !halt && hz.MemReqM && !hz.dmem_ready;
    frz  = mst || halt;
    lw   = !frz && hz.ResultSrcE == 2'b01 && hz.RdE != 5'd0 &&
           (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    e.fa = mfwd(hz.Rs1E);
    e.fb = mfwd(hz.Rs2E);
    e.sf = frz || lw;  e.sd = frz || lw;
    e.se = frz;        e.sm = frz;
    e.fd = !frz && hz.PCSrcE;
    e.fe = !frz && (hz.PCSrcE || lw);
    e.fw = frz;
    e.dreq = hz.MemReqM && !halt;
    e.err = m_err; e.st = m_state; e.cnt = m_cnt;
    exp_q.push_back(e);

    n_state = m_state;
    if (m_state == 2'b00 && mst) n_state = 2'b01;
    else if (m_state == 2'b01) begin
      if (mst && m_wcnt == TO - 1) n_state = 2'b10;
      else if (hz.dmem_ready)      n_state = 2'b00;
    end

    #1;
    e = exp_q.pop_front();
    check("ForwardAE",    32'(hz.ForwardAE),    32'(e.fa));
    check("ForwardBE",    32'(hz.ForwardBE),    32'(e.fb));
    check("stalls",       32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'({e.sf, e.sd, e.se, e.sm}));
    check("flushes",      32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'({e.fd, e.fe, e.fw}));
    check("dmem_req",     32'(hz.dmem_req),     32'(e.dreq));
    check("mem_err",      32'(hz.mem_err),      32'(e.err));
    check("state_o",      32'(hz.state_o),      32'(e.st));
    check("stall_cycles", 32'(hz.stall_cycles), 32'(e.cnt));

    @(posedge clk);
    m_wcnt  = mst ? m_wcnt + 1 : 0;
    if (n_state == 2'b10) m_err = 1'b1;
    if (e.sf && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    m_state = n_state;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", 32'(hz.state_o), 32'h0);
    check("rst_cnt",   32'(hz.stall_cycles), 32'h0);
    check("rst_err",   32'(hz.mem_err), 32'h0);
    rst = 1'b0;

    // Forwarding priority
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd5;
    #1 check("fwdA_M", 32'(hz.ForwardAE), 32'h2);
    cycle();
    hz.RdM = 5'd0;
    #1 check("fwdA_W", 32'(hz.ForwardAE), 32'h1);
    cycle();
    hz.Rs1E = 5'd0; hz.RdW = 5'd0;
    #1 check("fwdA_x0", 32'(hz.ForwardAE), 32'h0);
    cycle();
    hz.Rs2E = 5'd6; hz.RdM = 5'd6; hz.RdW = 5'd6;
    #1 check("fwdB_M", 32'(hz.ForwardBE), 32'h2);
    cycle();

    // Load-use
    reset_dut(); clear_in();
    hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1 check("lu_sig", 32'({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD}), 32'b1110);
    cycle();
    clear_in();
    check("lu_cnt", 32'(hz.stall_cycles), 32'h1);
    cycle();

    // Memory wait: 3 not-ready cycles then ready
    reset_dut(); clear_in();
    hz.MemReqM = 1'b1;
    repeat (3) cycle();
    check("mw_state_wait", 32'(hz.state_o), 32'h1);
    hz.dmem_ready = 1'b1;
    cycle();
    clear_in();
    check("mw_state_run", 32'(hz.state_o), 32'h0);
    check("mw_cnt", 32'(hz.stall_cycles), 32'h3);
    cycle();

    // Zero-wait access
    hz.MemReqM = 1'b1; hz.dmem_ready = 1'b1;
    cycle();
    check("zw_state", 32'(hz.state_o), 32'h0);

    // Branch deferred through a freeze
    reset_dut(); clear_in();
    hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1;
    #1 check("br_frozen", 32'({hz.FlushD, hz.FlushE}), 32'b00);
    cycle(); cycle();
    hz.dmem_ready = 1'b1;
    #1 check("br_release", 32'({hz.FlushD, hz.FlushE}), 32'b11);
    cycle();

    // Timeout, halt absorbing, counter saturation, async reset out of HALT
    reset_dut(); clear_in();
    hz.MemReqM = 1'b1;
    repeat (TO) cycle();
    check("to_state", 32'(hz.state_o), 32'h2);
    check("to_err",   32'(hz.mem_err), 32'h1);
    check("to_req",   32'(hz.dmem_req), 32'h0);
    check("to_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'b11111);
    hz.dmem_ready = 1'b1;
    repeat (3) cycle();
    check("to_absorb", 32'(hz.state_o), 32'h2);
    hz.dmem_ready = 1'b0;
    repeat (12) cycle();
    check("cnt_sat", 32'(hz.stall_cycles), 32'hF);
    #2 rst = 1'b1;
    #1;
    check("ar_halt_state", 32'(hz.state_o), 32'h0);
    check("ar_halt_err",   32'(hz.mem_err), 32'h0);
    check("ar_halt_cnt",   32'(hz.stall_cycles), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-WAIT
    clear_in();
    hz.MemReqM = 1'b1;
    repeat (2) cycle();
    check("ar_wait_pre", 32'(hz.state_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_wait_state", 32'(hz.state_o), 32'h0);
    check("ar_wait_cnt",   32'(hz.stall_cycles), 32'h0);
    check("ar_wait_err",   32'(hz.mem_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random mix against the model
    clear_in();
    repeat (200) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.RegWriteM  = 1'($urandom_range(0, 1));
      hz.RegWriteW  = 1'($urandom_range(0, 1));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE     = ($urandom_range(0, 3) == 0);
      hz.MemReqM    = ($urandom_range(0, 3) == 0);
      hz.dmem_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
